// File: rtl/simple_isa_pkg.sv
// simple_isa_pkg: SIMPLE ISA field encodings, sequencer states, flag bit positions and decode helpers.
//   Items: PHASES; OP1_*/OP2_*/OP3_*/CND_* field codes; ALU_* opcodes; FLG_* flag indices;
//   state_e; phase_onehot(); flag_wr(); arith_wr().
package simple_isa_pkg;
    localparam int PHASES = 5;
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_CTL = 2'b10;
    localparam logic [1:0] OP1_ARI = 2'b11;
    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BC  = 3'b111;
    localparam logic [3:0] OP3_CMP = 4'd5;
    localparam logic [3:0] OP3_UND = 4'd7;
    localparam logic [3:0] OP3_HLT = 4'd15;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_LI  = 4'd6;
    // 7 is the ALU no-op; holding it while idle keeps alu_hlt low.
    localparam logic [3:0] ALU_NOP = 4'd7;
    localparam logic [2:0] CND_BE  = 3'b000;
    localparam logic [2:0] CND_BLT = 3'b001;
    localparam logic [2:0] CND_BLE = 3'b010;
    localparam logic [2:0] CND_BNE = 3'b011;
    localparam int FLG_S = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 0;
    typedef enum logic [2:0] {ST_IDLE, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_HALT} state_e;
    function automatic logic [PHASES-1:0] phase_onehot(input state_e s);
        return {s == ST_P5, s == ST_P4, s == ST_P3, s == ST_P2, s == ST_P1};
    endfunction
    // Arithmetic op3 values that latch the ALU flags at the end of P3.
    function automatic logic flag_wr(input logic [3:0] op3);
        return op3 <= 4'd11 && op3 != OP3_UND;
    endfunction
    // Arithmetic op3 values that write a register in P5 (CMP only sets flags).
    function automatic logic arith_wr(input logic [3:0] op3);
        return op3 <= 4'd12 && op3 != OP3_CMP && op3 != OP3_UND;
    endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational conditional-branch evaluation against the {S,Z,C,V} flags.
//   cond  in  3  branch condition field IR[10:8]
//   flags in  4  registered {S,Z,C,V}
//   taken out 1  condition holds
module branch_cond_eval
    import simple_isa_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);
    logic lt;
    always_comb begin
        lt    = flags[FLG_S] ^ flags[FLG_V];
        taken = cond == CND_BE  ? flags[FLG_Z] :
                cond == CND_BLT ? lt :
                cond == CND_BLE ? flags[FLG_Z] | lt :
                cond == CND_BNE ? !flags[FLG_Z] : 1'b0;
    end
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: five-phase instruction sequencer for the SIMPLE core (IR, flags, branch and strobe decode).
//   clk, rst_n (async, active-low); run start/resume; imem_data instruction word in P1;
//   alu_s/z/c/v, alu_hlt sampled at end of P3.
//   phase one-hot {P5..P1}; pc_inc (P1); alu_op/alu_d to ALU; dmem_re/dmem_we (P4);
//   reg_we/pc_ld (P5); flags {S,Z,C,V}; halted.
// All outputs are registered and decoded from the next state, so each strobe lines up with its phase.
module phase_sequencer
    import simple_isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [15:0]       imem_data,
    input  logic              alu_s,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              alu_hlt,
    output logic [PHASES-1:0] phase,
    output logic              pc_inc,
    output logic [3:0]        alu_op,
    output logic [3:0]        alu_d,
    output logic              dmem_re,
    output logic              dmem_we,
    output logic              reg_we,
    output logic              pc_ld,
    output logic [3:0]        flags,
    output logic              halted
);
    state_e state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0] flags_q, flags_d, alu_op_q, alu_op_d, alu_d_q, alu_d_d;
    logic [PHASES-1:0] phase_q, phase_d;
    logic pc_inc_q, pc_inc_d, dmem_re_q, dmem_re_d, dmem_we_q, dmem_we_d;
    logic reg_we_q, reg_we_d, pc_ld_q, pc_ld_d, halted_q, halted_d;
    logic run_prev_q, taken, hlt, busy;
    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;

    always_comb begin
        ir_d = state_q == ST_P1 ? imem_data : ir_q;
    end

    // Flags are already final when P5 is entered, so branches see the registered value.
    branch_cond_eval u_cond (
        .cond  (ir_d[10:8]),
        .flags (flags_q),
        .taken (taken)
    );

    always_comb begin
        hlt      = state_q == ST_P3 && alu_hlt && ir_q[15:14] == OP1_ARI && ir_q[7:4] == OP3_HLT;
        // HALT resumes only on a rising edge of run, so a held run cannot re-launch a halted core.
        state_d  = state_q == ST_IDLE ? (run ? ST_P1 : ST_IDLE) :
                   state_q == ST_HALT ? (run && !run_prev_q ? ST_P1 : ST_HALT) :
                   hlt                ? ST_HALT :
                   state_q == ST_P5   ? ST_P1 : state_e'(state_q + 3'd1);
        flags_d  = state_q == ST_P3 && ir_q[15:14] == OP1_ARI && flag_wr(ir_q[7:4]) ?
                   {alu_s, alu_z, alu_c, alu_v} : flags_q;
        op1      = ir_d[15:14];
        op2      = ir_d[13:11];
        op3      = ir_d[7:4];
        busy     = state_d >= ST_P2 && state_d <= ST_P5;
        alu_op_d = !busy                         ? ALU_NOP :
                   op1 == OP1_ARI                ? op3 :
                   op1 == OP1_LD || op1 == OP1_ST ? ALU_ADD :
                   op1 == OP1_CTL && op2 == OP2_LI ? ALU_LI : ALU_NOP;
        alu_d_d  = busy ? ir_d[3:0] : ALU_NOP;
        phase_d  = phase_onehot(state_d);
        pc_inc_d = state_d == ST_P1;
        dmem_re_d = state_d == ST_P4 && op1 == OP1_LD;
        dmem_we_d = state_d == ST_P4 && op1 == OP1_ST;
        reg_we_d = state_d == ST_P5 && (op1 == OP1_LD || (op1 == OP1_CTL && op2 == OP2_LI) ||
                   (op1 == OP1_ARI && arith_wr(op3)));
        pc_ld_d  = state_d == ST_P5 && op1 == OP1_CTL && (op2 == OP2_B || (op2 == OP2_BC && taken));
        halted_d = state_d == ST_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            flags_q    <= '0;
            run_prev_q <= 1'b0;
            phase_q    <= '0;
            pc_inc_q   <= 1'b0;
            alu_op_q   <= ALU_NOP;
            alu_d_q    <= ALU_NOP;
            dmem_re_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            pc_ld_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            flags_q    <= flags_d;
            run_prev_q <= run;
            phase_q    <= phase_d;
            pc_inc_q   <= pc_inc_d;
            alu_op_q   <= alu_op_d;
            alu_d_q    <= alu_d_d;
            dmem_re_q  <= dmem_re_d;
            dmem_we_q  <= dmem_we_d;
            reg_we_q   <= reg_we_d;
            pc_ld_q    <= pc_ld_d;
            halted_q   <= halted_d;
        end
    end

    assign phase   = phase_q;
    assign pc_inc  = pc_inc_q;
    assign alu_op  = alu_op_q;
    assign alu_d   = alu_d_q;
    assign dmem_re = dmem_re_q;
    assign dmem_we = dmem_we_q;
    assign reg_we  = reg_we_q;
    assign pc_ld   = pc_ld_q;
    assign flags   = flags_q;
    assign halted  = halted_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed, table-driven checks of phase_sequencer plus halt and mid-instruction reset sequences.
module tb_phase_sequencer;
    logic clk, rst_n, run, alu_s, alu_z, alu_c, alu_v, alu_hlt;
    logic [15:0] imem_data;
    logic [4:0] phase;
    logic pc_inc, dmem_re, dmem_we, reg_we, pc_ld, halted;
    logic [3:0] alu_op, alu_d, flags;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  af;
        logic [3:0]  op;
        logic        re, we, rw, pl;
        logic [3:0]  fl;
    } vec_t;
    vec_t tab[20];

    phase_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_data(imem_data),
        .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_hlt(alu_hlt),
        .phase(phase), .pc_inc(pc_inc), .alu_op(alu_op), .alu_d(alu_d),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .reg_we(reg_we), .pc_ld(pc_ld),
        .flags(flags), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in P1; leaves it in P5.
    task automatic do_instr(input vec_t v);
        imem_data = v.ir;
        {alu_s, alu_z, alu_c, alu_v} = v.af;
        alu_hlt = 1'b0;
        for (int p = 0; p < 5; p++) begin
            if (p > 0) tick();
            chk("phase", 16'(phase), 16'(16'd1 << p));
            chk("pc_inc", 16'(pc_inc), 16'(p == 0));
            chk("alu_op", 16'(alu_op), 16'(p == 0 ? 4'h7 : v.op));
            chk("alu_d", 16'(alu_d), 16'(p == 0 ? 4'h7 : v.ir[3:0]));
            chk("dmem_re", 16'(dmem_re), 16'(p == 3 && v.re));
            chk("dmem_we", 16'(dmem_we), 16'(p == 3 && v.we));
            chk("reg_we", 16'(reg_we), 16'(p == 4 && v.rw));
            chk("pc_ld", 16'(pc_ld), 16'(p == 4 && v.pl));
            chk("halted", 16'(halted), 16'd0);
            if (p >= 3) chk("flags", 16'(flags), 16'(v.fl));
        end
    endtask

    initial begin
        //            ir       alu_f    op     re    we    rw    pl    flags
        tab[0]  = '{16'hC003, 4'b0100, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0100}; // ADD
        tab[1]  = '{16'hC050, 4'b1000, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1000}; // CMP
        tab[2]  = '{16'hB900, 4'b0110, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'b1000}; // BLT S^V=1
        tab[3]  = '{16'h0123, 4'b0001, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'b1000}; // LD
        tab[4]  = '{16'h4567, 4'b0001, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'b1000}; // ST
        tab[5]  = '{16'h8012, 4'b0001, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 4'b1000}; // LI
        tab[6]  = '{16'hC010, 4'b0100, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0100}; // SUB Z=1
        tab[7]  = '{16'hBB00, 4'b0000, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0100}; // BNE Z=1
        tab[8]  = '{16'hB800, 4'b0000, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0100}; // BE Z=1
        tab[9]  = '{16'hBE00, 4'b0000, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0100}; // cond 110
        tab[10] = '{16'hA000, 4'b0000, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0100}; // B
        tab[11] = '{16'hC0E0, 4'b1111, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100}; // op3 14
        tab[12] = '{16'hC0D0, 4'b0011, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100}; // OUT
        tab[13] = '{16'hC0C0, 4'b0011, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100}; // op3 12
        tab[14] = '{16'hC080, 4'b0011, 4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0011}; // op3 8
        tab[15] = '{16'hBA00, 4'b0000, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0011}; // BLE S^V=1
        tab[16] = '{16'hC070, 4'b1111, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0011}; // op3 7
        tab[17] = '{16'hAD00, 4'b1111, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0011}; // op2 101
        tab[18] = '{16'hBB00, 4'b0000, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0011}; // BNE Z=0
        tab[19] = '{16'hC021, 4'b0110, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 4'b0110}; // op3 2, after resume

        rst_n = 1'b0; run = 1'b0; imem_data = '0; alu_hlt = 1'b0;
        {alu_s, alu_z, alu_c, alu_v} = 4'b0000;
        repeat (3) tick();
        chk("rst_phase", 16'(phase), 16'd0);
        chk("rst_flags", 16'(flags), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_strobes", 16'({pc_inc, dmem_re, dmem_we, reg_we, pc_ld}), 16'd0);
        chk("rst_alu_op", 16'(alu_op), 16'h7);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_phase", 16'(phase), 16'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 19; i++) begin
            do_instr(tab[i]);
            tick();
        end

        // HLT with run held high throughout: must halt and stay halted.
        imem_data = 16'hC0F0; {alu_s, alu_z, alu_c, alu_v} = 4'b1111; alu_hlt = 1'b1; run = 1'b1;
        chk("hlt_p1", 16'(phase), 16'd1);
        tick();
        chk("hlt_p2", 16'(phase), 16'd2);
        tick();
        chk("hlt_p3", 16'(phase), 16'd4);
        tick();
        alu_hlt = 1'b0;
        chk("halt_halted", 16'(halted), 16'd1);
        chk("halt_phase", 16'(phase), 16'd0);
        chk("halt_flags", 16'(flags), 16'b0011);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold", 16'({halted, phase}), 16'h20);
            chk("halt_strobes", 16'({pc_inc, dmem_re, dmem_we, reg_we, pc_ld}), 16'd0);
            chk("halt_alu_op", 16'(alu_op), 16'h7);
        end
        run = 1'b0;
        tick();
        chk("halt_run_low", 16'(halted), 16'd1);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("resume_phase", 16'(phase), 16'd1);
        chk("resume_pc_inc", 16'(pc_inc), 16'd1);
        chk("resume_halted", 16'(halted), 16'd0);
        do_instr(tab[19]);
        tick();

        // ST interrupted by reset in P4.
        imem_data = 16'h4000;
        repeat (3) tick();
        chk("st_p4_phase", 16'(phase), 16'h8);
        chk("st_p4_we", 16'(dmem_we), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", 16'(dmem_we), 16'd0);
        chk("arst_phase", 16'(phase), 16'd0);
        chk("arst_flags", 16'(flags), 16'd0);
        chk("arst_alu_op", 16'(alu_op), 16'h7);
        #3 rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_idle", 16'({phase, pc_inc, dmem_we}), 16'd0);
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("restart_phase", 16'(phase), 16'd1);
        chk("restart_pc_inc", 16'(pc_inc), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
